object_buffer_fifo: RTL and testbench
=====================================

Name: object_buffer_fifo

Overview:
Parametrised successor to the single-port object buffer. Stores TABLE_ENTRY-style records (default 128 bits) pushed by the parser front-end in a circular FIFO of configurable depth. Adds a pop-side valid/ready handshake toward the serializer, occupancy count, almost-full warning, synchronous flush and a sticky overflow flag. Sits between the field-table decoder and the object serializer.

Parameters:
ENTRY_W, 128, width of one entry in bits (TABLE_ENTRY width).
DEPTH, 8, number of entries; any integer >= 2, not required to be a power of two.
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
CNT_W, $clog2(DEPTH+1), width of the count output (derived, do not override).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset).
new_entry  input  ENTRY_W  entry to push.
valid_in  input  1  push request.
full  output  1  count == DEPTH.
almost_full  output  1  count >= AF_THRESH.
out_entry  output  ENTRY_W  head entry (show-ahead).
out_valid  output  1  head entry valid (== !empty).
out_ready  input  1  consumer accepts head this cycle.
empty  output  1  count == 0.
count  output  CNT_W  current occupancy.
flush  input  1  synchronous clear.
overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (reset==0, async): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs follow: empty=1, out_valid=0, full=0, almost_full=0 (almost_full=1 only if AF_THRESH==0, which is illegal). out_entry is don't-care; storage is not cleared.
- pop = out_valid && out_ready.
- push_ok = valid_in && (!full || pop). A push into a full FIFO is accepted when a pop occurs in the same cycle.
- On push_ok: mem[wr_ptr] <= new_entry; wr_ptr advances and wraps to 0 after DEPTH-1.
- On pop: rd_ptr advances and wraps to 0 after DEPTH-1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Drop: if valid_in && !push_ok, the entry is discarded, no state changes, and overflow <= 1. overflow stays set until flush or reset.
- Pop while empty is impossible because out_valid=0; out_ready is ignored when empty.
- Latency: an entry pushed at edge N appears on out_entry with out_valid=1 after edge N, provided it is at the head. No same-cycle bypass: when empty, out_valid stays 0 in the push cycle.
- Show-ahead: out_entry = mem[rd_ptr], combinational from registered rd_ptr. It must stay stable while out_valid && !out_ready.
- flush (synchronous, highest priority): pointers, count and overflow are set to 0. A push or pop in the same cycle is ignored, and overflow is not set by a push in a flush cycle.
- full, empty, almost_full and out_valid decode combinationally from count only, never from input ports.
- All state is held in flops; no latches; no X propagation from mem into control.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Behaviour after deassertion is identical to a fresh reset.

Test Plan:
- Reset/basic: hold reset=0 for 2 cycles, then release. Push 128'h0000_0009_4018_0008_DEAD_BEEF_0000_0001 for 1 cycle -> next cycle count=1, out_valid=1, out_entry equals that value, empty=0.
- Fill/full: DEPTH=8, push 8 entries 1..8 with out_ready=0 -> count=8, full=1, almost_full asserted at count=6. A 9th push (value 9) -> dropped, overflow=1, count stays 8. Pop all 8 -> order 1..8, then empty=1.
- Simultaneous push+pop when full: full FIFO, valid_in=1 and out_ready=1 for 1 cycle -> count stays 8, overflow stays 0, and the new entry appears last after the 7 older entries drain.
- Wrap-around: DEPTH=5, 12 rounds of push 3/pop 3 with incrementing data -> every popped value matches pushed order. Pointers wrap with no loss; count returns to 0 each round.
- Backpressure: 3 entries held with out_ready=0 for 5 cycles -> out_entry stable and out_valid=1 throughout. Then raise out_ready -> one entry per cycle.
- Flush/async reset: 4 entries with overflow=1, assert flush together with valid_in=1 -> next cycle count=0, overflow=0, empty=1. Refill 2 entries, pulse reset low mid-cycle -> count=0 and empty=1 before the next clock edge.

Source files
------------

// File: rtl/object_buffer_fifo.sv
// Circular show-ahead FIFO for parsed table entries, sitting between the field-table
// decoder and the object serializer; adds occupancy, almost-full, flush and sticky overflow.
module object_buffer_fifo #(
  parameter int ENTRY_W   = 128,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ENTRY_W-1:0] new_entry,
  input  logic               valid_in,
  output logic               full,
  output logic               almost_full,
  output logic [ENTRY_W-1:0] out_entry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  input  logic               flush,
  output logic               overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  logic [PTR_W-1:0]   w_wr_ptr_inc;
  logic [PTR_W-1:0]   w_rd_ptr_inc;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_drop;

  // Status decodes depend on the registered count only, never on input ports.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && out_ready;
  assign w_push_ok = valid_in && (!w_full || w_pop);
  assign w_drop    = valid_in && !w_push_ok;

  // Explicit wrap so DEPTH need not be a power of two.
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)     r_rd_ptr <= w_rd_ptr_inc;
      if (w_push_ok && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push_ok) r_count <= r_count - CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && !flush && w_push_ok) r_mem[r_wr_ptr] <= new_entry;
  end

  assign out_entry   = r_mem[r_rd_ptr];
  assign out_valid   = !w_empty;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= CNT_W'(AF_THRESH));
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_object_buffer_fifo.sv
// Drives a DEPTH=8 and a DEPTH=5 FIFO with shared stimulus and compares each against
// a queue-based model of the occupancy/ordering rules.
module tb_object_buffer_fifo;

  typedef logic [127:0] ent_q_t[$];

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] new_entry;
  logic         valid_in;
  logic         out_ready;
  logic         flush;

  logic         a_full, a_af, a_valid, a_empty, a_ovf;
  logic [127:0] a_entry;
  logic [3:0]   a_count;
  logic         b_full, b_af, b_valid, b_empty, b_ovf;
  logic [127:0] b_entry;
  logic [2:0]   b_count;

  ent_q_t mq_a, mq_b;
  bit     mov_a, mov_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  object_buffer_fifo #(.ENTRY_W(128), .DEPTH(8)) u_dut_a (
    .clk(clk), .reset(reset), .new_entry(new_entry), .valid_in(valid_in),
    .full(a_full), .almost_full(a_af), .out_entry(a_entry), .out_valid(a_valid),
    .out_ready(out_ready), .empty(a_empty), .count(a_count), .flush(flush),
    .overflow(a_ovf)
  );

  object_buffer_fifo #(.ENTRY_W(128), .DEPTH(5)) u_dut_b (
    .clk(clk), .reset(reset), .new_entry(new_entry), .valid_in(valid_in),
    .full(b_full), .almost_full(b_af), .out_entry(b_entry), .out_valid(b_valid),
    .out_ready(out_ready), .empty(b_empty), .count(b_count), .flush(flush),
    .overflow(b_ovf)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input ent_q_t q, input bit ov, input int depth,
                           input int thresh, input logic [31:0] cnt, input logic full_o,
                           input logic af_o, input logic empty_o, input logic valid_o,
                           input logic ovf_o, input logic [127:0] ent_o);
    int sz;
    sz = q.size();
    check_eq({nm, ".count"}, 128'(cnt), 128'(sz));
    check_eq({nm, ".full"}, 128'(full_o), 128'(sz == depth));
    check_eq({nm, ".almost_full"}, 128'(af_o), 128'(sz >= thresh));
    check_eq({nm, ".empty"}, 128'(empty_o), 128'(sz == 0));
    check_eq({nm, ".out_valid"}, 128'(valid_o), 128'(sz != 0));
    check_eq({nm, ".overflow"}, 128'(ovf_o), 128'(ov));
    if (sz != 0) check_eq({nm, ".out_entry"}, ent_o, q[0]);
  endtask

  task automatic model_step(inout ent_q_t q, inout bit ov, input int depth);
    bit pop, push_ok;
    if (flush) begin
      q.delete();
      ov = 1'b0;
    end else begin
      pop     = (q.size() > 0) && out_ready;
      push_ok = valid_in && ((q.size() < depth) || pop);
      if (pop) void'(q.pop_front());
      if (push_ok) q.push_back(new_entry);
      if (valid_in && !push_ok) ov = 1'b1;
    end
  endtask

  task automatic check_all();
    check_dut("d8", mq_a, mov_a, 8, 6, 32'(a_count), a_full, a_af, a_empty, a_valid, a_ovf, a_entry);
    check_dut("d5", mq_b, mov_b, 5, 3, 32'(b_count), b_full, b_af, b_empty, b_valid, b_ovf, b_entry);
  endtask

  // Inputs are already applied; check pre-edge state at negedge, then advance model and clock.
  task automatic cycle();
    @(negedge clk);
    check_all();
    $display("cyc t=%0t vin=%0b rdy=%0b fl=%0b data=%h d8.cnt=%0d d5.cnt=%0d",
             $time, valid_in, out_ready, flush, new_entry, a_count, b_count);
    model_step(mq_a, mov_a, 8);
    model_step(mq_b, mov_b, 5);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic r, input logic f);
    valid_in  = v;
    new_entry = d;
    out_ready = r;
    flush     = f;
    cycle();
  endtask

  logic [127:0] data;

  initial begin
    reset = 1'b0; valid_in = 1'b0; out_ready = 1'b0; flush = 1'b0; new_entry = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // basic push, show-ahead after one edge
    drive(1'b1, 128'h0000_0009_4018_0008_DEAD_BEEF_0000_0001, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // fill 1..8, drop 9, drain
    for (int i = 1; i <= 9; i++) drive(1'b1, 128'(i), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);

    // simultaneous push+pop on full
    for (int i = 1; i <= 8; i++) drive(1'b1, 128'(16 + i), 1'b0, 1'b0);
    drive(1'b1, 128'h100, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);

    // wrap-around rounds
    data = 128'h1000;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, data, 1'b0, 1'b0);
        data = data + 128'd1;
      end
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
    end

    // backpressure: head held stable for 5 cycles
    for (int i = 0; i < 3; i++) drive(1'b1, {96'hABCD, 32'(i)}, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      check_eq("hold.d8.out_entry", a_entry, {96'hABCD, 32'd0});
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);

    // flush beats push and clears overflow
    for (int i = 0; i < 9; i++) drive(1'b1, 128'(32 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 128'h77, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);

    // asynchronous reset mid-cycle
    drive(1'b1, 128'h55, 1'b0, 1'b0);
    drive(1'b1, 128'h66, 1'b0, 1'b0);
    valid_in = 1'b0;
    reset = 1'b0;
    #2;
    check_eq("async.d8.count", 128'(a_count), 128'd0);
    check_eq("async.d8.empty", 128'(a_empty), 128'd1);
    check_eq("async.d5.count", 128'(b_count), 128'd0);
    check_eq("async.d5.empty", 128'(b_empty), 128'd1);
    mq_a.delete(); mq_b.delete(); mov_a = 1'b0; mov_b = 1'b0;
    #1;
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 99) < 60), {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3));
    drive(1'b0, '0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
